// File: rtl/delay_window_monitor_pkg.sv
// Shared limits, types and arithmetic helpers for the delay-window monitor.
package delay_window_pkg;

  localparam int MAX_DELAY_LIMIT = 32;
  localparam int MAX_CH_LIMIT    = 16;

  typedef logic [MAX_DELAY_LIMIT:1] delay_vec_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  // Adds inc to count and clamps at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_add(input logic [31:0] count, input logic [5:0] inc,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, count} + {27'd0, inc};
    max = (33'd1 << width) - 33'd1;
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/delay_window_monitor_if.sv
// Bundles the monitor's control inputs, a/b probes and reported results.
interface delay_window_monitor_if #(
  parameter int NUM_CH  = 2,
  parameter int COUNT_W = 16
);
  logic                      en;
  logic                      clear;
  logic [NUM_CH-1:0]         a;
  logic [NUM_CH-1:0]         b;
  logic [NUM_CH-1:0]         match;
  logic [NUM_CH-1:0]         fail;
  logic [NUM_CH*COUNT_W-1:0] match_count;
  logic [NUM_CH*COUNT_W-1:0] fail_count;
  logic [NUM_CH-1:0]         busy;

  modport master (output en, clear, a, b,
                  input  match, fail, match_count, fail_count, busy);
  modport slave  (input  en, clear, a, b,
                  output match, fail, match_count, fail_count, busy);
endinterface

// File: rtl/delay_window_monitor_channel.sv
// One channel: pending-attempt shift vector, window retire logic, result pulses and counters.
module delay_window_channel
  import delay_window_pkg::*;
#(
  parameter int MIN_DELAY  = 1,
  parameter int MAX_DELAY  = 3,
  parameter bit KILL_EARLY = 1'b0,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic               a_i,
  input  logic               b_i,
  output logic               match_o,
  output logic               fail_o,
  output logic               busy_o,
  output logic [COUNT_W-1:0] match_count_o,
  output logic [COUNT_W-1:0] fail_count_o
);

  logic [MAX_DELAY:1] p_q, p_d;
  delay_vec_t         retire_m, retire_f;
  logic               match_q, fail_q, busy_q;
  logic [COUNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [COUNT_W-1:0] fail_cnt_q, fail_cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    retire_m = '0;
    retire_f = '0;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (k >= MIN_DELAY) retire_m[k] = p_q[k] & b_i;
      else if (KILL_EARLY) retire_f[k] = p_q[k] & b_i;
    end
    // The oldest attempt times out when b is absent at the window's last offset.
    retire_f[MAX_DELAY] = retire_f[MAX_DELAY] | (p_q[MAX_DELAY] & ~b_i);
  end

  // A new attempt enters at age 1, so b in the same cycle only sees older attempts.
  always_comb begin
    p_d    = '0;
    p_d[1] = en_i & a_i;
    for (int k = 1; k < MAX_DELAY; k++) p_d[k+1] = p_q[k] & ~retire_m[k] & ~retire_f[k];
  end

  assign match_cnt_d = COUNT_W'(sat_add(32'(match_cnt_q), popcount32(retire_m), COUNT_W));
  assign fail_cnt_d  = COUNT_W'(sat_add(32'(fail_cnt_q), popcount32(retire_f), COUNT_W));

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: reset is synchronous; clear shares the path since both zero the same state.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      p_q         <= '0;
      match_q     <= 1'b0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
      match_cnt_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      p_q         <= p_d;
      match_q     <= |retire_m;
      fail_q      <= |retire_f;
      busy_q      <= |p_d;
      match_cnt_q <= match_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign match_o       = match_q;
  assign fail_o        = fail_q;
  assign busy_o        = busy_q;
  assign match_count_o = match_cnt_q;
  assign fail_count_o  = fail_cnt_q;

endmodule

// File: rtl/delay_window_monitor.sv
// Multi-channel "a followed by b within [MIN_DELAY:MAX_DELAY]" monitor; interface widths must match NUM_CH/COUNT_W.
module delay_window_monitor
  import delay_window_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int MIN_DELAY  = 1,
  parameter int MAX_DELAY  = 3,
  parameter bit KILL_EARLY = 1'b0,
  parameter int COUNT_W    = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  delay_window_monitor_if.slave mon
);

  if (MIN_DELAY < 1) begin : g_bad_min
    $error("delay_window_monitor: MIN_DELAY must be >= 1");
  end
  if (MAX_DELAY < MIN_DELAY) begin : g_bad_window
    $error("delay_window_monitor: MAX_DELAY must be >= MIN_DELAY");
  end
  if (MAX_DELAY > MAX_DELAY_LIMIT) begin : g_bad_max
    $error("delay_window_monitor: MAX_DELAY exceeds limit");
  end
  if (NUM_CH < 1 || NUM_CH > MAX_CH_LIMIT) begin : g_bad_ch
    $error("delay_window_monitor: NUM_CH out of range");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    delay_window_channel #(
      .MIN_DELAY (MIN_DELAY),
      .MAX_DELAY (MAX_DELAY),
      .KILL_EARLY(KILL_EARLY),
      .COUNT_W   (COUNT_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (mon.en),
      .clear_i      (mon.clear),
      .a_i          (mon.a[c]),
      .b_i          (mon.b[c]),
      .match_o      (mon.match[c]),
      .fail_o       (mon.fail[c]),
      .busy_o       (mon.busy[c]),
      .match_count_o(mon.match_count[c*COUNT_W +: COUNT_W]),
      .fail_count_o (mon.fail_count[c*COUNT_W +: COUNT_W])
    );
  end

endmodule

// File: tb/tb_delay_window_monitor.sv
// Scoreboard bench: five monitor configurations, directed vectors, queued expectations checked on output.
module tb_delay_window_monitor;

  typedef struct {
    int         dut;
    int         cyc;
    logic [1:0] m, f, busy;
    logic [15:0] mc0, mc1, fc0, fc1;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   base;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  delay_window_monitor_if #(.NUM_CH(2), .COUNT_W(16)) if0 ();
  delay_window_monitor_if #(.NUM_CH(2), .COUNT_W(16)) if1 ();
  delay_window_monitor_if #(.NUM_CH(2), .COUNT_W(16)) if2 ();
  delay_window_monitor_if #(.NUM_CH(2), .COUNT_W(16)) if3 ();
  delay_window_monitor_if #(.NUM_CH(2), .COUNT_W(2))  if4 ();

  delay_window_monitor #(.NUM_CH(2), .MIN_DELAY(1), .MAX_DELAY(1), .KILL_EARLY(1'b0), .COUNT_W(16))
    dut0 (.clk(clk), .rst_n(rst_n), .mon(if0));
  delay_window_monitor #(.NUM_CH(2), .MIN_DELAY(1), .MAX_DELAY(3), .KILL_EARLY(1'b0), .COUNT_W(16))
    dut1 (.clk(clk), .rst_n(rst_n), .mon(if1));
  delay_window_monitor #(.NUM_CH(2), .MIN_DELAY(2), .MAX_DELAY(3), .KILL_EARLY(1'b1), .COUNT_W(16))
    dut2 (.clk(clk), .rst_n(rst_n), .mon(if2));
  delay_window_monitor #(.NUM_CH(2), .MIN_DELAY(2), .MAX_DELAY(3), .KILL_EARLY(1'b0), .COUNT_W(16))
    dut3 (.clk(clk), .rst_n(rst_n), .mon(if3));
  delay_window_monitor #(.NUM_CH(2), .MIN_DELAY(1), .MAX_DELAY(1), .KILL_EARLY(1'b0), .COUNT_W(2))
    dut4 (.clk(clk), .rst_n(rst_n), .mon(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [127:0] pack(input int id, input int c, input logic [1:0] m, f, busy,
                                        input logic [15:0] mc0, mc1, fc0, fc1);
    return 128'({16'(id), 16'(c), m, f, busy, mc0, mc1, fc0, fc1});
  endfunction

  // Expectation for DUT d at cycle t of the current test (t counted from the end of reset).
  task automatic exp(input int d, input int t, input logic [1:0] m, f, busy,
                     input logic [15:0] mc0, mc1, fc0, fc1);
    exp_t e;
    e.dut = d; e.cyc = base + t; e.m = m; e.f = f; e.busy = busy;
    e.mc0 = mc0; e.mc1 = mc1; e.fc0 = fc0; e.fc1 = fc1;
    sb_q.push_back(e);
  endtask

  // Monitor: compares when the DUT pulses or when an expectation for it falls due this cycle.
  task automatic observe(input int id, input logic [1:0] m, f, busy,
                         input logic [15:0] mc0, mc1, fc0, fc1);
    exp_t e;
    bit   due;
    due = (sb_q.size() > 0) && (sb_q[0].dut == id) && (sb_q[0].cyc == cyc);
    if (!(due || m != 2'b00 || f != 2'b00)) return;
    if (sb_q.size() == 0) begin
      check($sformatf("unexpected_pulse_d%0d_c%0d", id, cyc), 128'({m, f}), 128'(0));
      return;
    end
    e = sb_q.pop_front();
    check($sformatf("d%0d_c%0d", e.dut, e.cyc),
          pack(id, cyc, m, f, busy, mc0, mc1, fc0, fc1),
          pack(e.dut, e.cyc, e.m, e.f, e.busy, e.mc0, e.mc1, e.fc0, e.fc1));
  endtask

  always @(negedge clk) observe(0, if0.match, if0.fail, if0.busy, if0.match_count[15:0],
                                if0.match_count[31:16], if0.fail_count[15:0], if0.fail_count[31:16]);
  always @(negedge clk) observe(1, if1.match, if1.fail, if1.busy, if1.match_count[15:0],
                                if1.match_count[31:16], if1.fail_count[15:0], if1.fail_count[31:16]);
  always @(negedge clk) observe(2, if2.match, if2.fail, if2.busy, if2.match_count[15:0],
                                if2.match_count[31:16], if2.fail_count[15:0], if2.fail_count[31:16]);
  always @(negedge clk) observe(3, if3.match, if3.fail, if3.busy, if3.match_count[15:0],
                                if3.match_count[31:16], if3.fail_count[15:0], if3.fail_count[31:16]);
  always @(negedge clk) observe(4, if4.match, if4.fail, if4.busy, 16'(if4.match_count[1:0]),
                                16'(if4.match_count[3:2]), 16'(if4.fail_count[1:0]), 16'(if4.fail_count[3:2]));

  // An expectation still queued after its cycle's sampling point means the DUT never presented it.
  always @(posedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      n_checks++;
      n_errors++;
      $display("FAIL missed_d%0d_c%0d no output at expected cycle", sb_q[0].dut, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
    cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if0.en = 1'b0; if0.clear = 1'b0; if0.a = '0; if0.b = '0;
    if1.en = 1'b0; if1.clear = 1'b0; if1.a = '0; if1.b = '0;
    if2.en = 1'b0; if2.clear = 1'b0; if2.a = '0; if2.b = '0;
    if3.en = 1'b0; if3.clear = 1'b0; if3.a = '0; if3.b = '0;
    if4.en = 1'b0; if4.clear = 1'b0; if4.a = '0; if4.b = '0;
  endtask

  // Drive one cycle of inputs on DUT d (others idle), then advance to the next cycle.
  task automatic cd(input int d, input logic en, input logic clr, input logic [1:0] a, input logic [1:0] b);
    idle_all();
    case (d)
      0: begin if0.en = en; if0.clear = clr; if0.a = a; if0.b = b; end
      1: begin if1.en = en; if1.clear = clr; if1.a = a; if1.b = b; end
      2: begin if2.en = en; if2.clear = clr; if2.a = a; if2.b = b; end
      3: begin if3.en = en; if3.clear = clr; if3.a = a; if3.b = b; end
      default: begin if4.en = en; if4.clear = clr; if4.a = a; if4.b = b; end
    endcase
    step();
  endtask

  task automatic start_test();
    idle_all();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    base  = cyc;
  endtask

  task automatic idle_cycles(input int d, input int n);
    for (int i = 0; i < n; i++) cd(d, 1'b1, 1'b0, 2'b00, 2'b00);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    idle_all();
    step();

    // MIN=MAX=1: a then b matches; a then no b fails.
    start_test();
    exp(0, 0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    exp(0, 1, 2'b00, 2'b00, 2'b01, 16'd0, 16'd0, 16'd0, 16'd0);
    exp(0, 2, 2'b01, 2'b00, 2'b00, 16'd1, 16'd0, 16'd0, 16'd0);
    exp(0, 4, 2'b00, 2'b00, 2'b01, 16'd1, 16'd0, 16'd0, 16'd0);
    exp(0, 5, 2'b00, 2'b01, 2'b00, 16'd1, 16'd0, 16'd1, 16'd0);
    cd(0, 1'b1, 1'b0, 2'b01, 2'b00);
    cd(0, 1'b1, 1'b0, 2'b00, 2'b01);
    cd(0, 1'b1, 1'b0, 2'b00, 2'b00);
    cd(0, 1'b1, 1'b0, 2'b01, 2'b00);
    idle_cycles(0, 4);

    // MIN=1, MAX=3: three overlapping attempts retired by one b; ch1 times out at age 3.
    start_test();
    exp(1, 0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    exp(1, 3, 2'b00, 2'b00, 2'b01, 16'd0, 16'd0, 16'd0, 16'd0);
    exp(1, 4, 2'b01, 2'b00, 2'b00, 16'd3, 16'd0, 16'd0, 16'd0);
    exp(1, 8, 2'b00, 2'b00, 2'b10, 16'd3, 16'd0, 16'd0, 16'd0);
    exp(1, 9, 2'b00, 2'b10, 2'b00, 16'd3, 16'd0, 16'd0, 16'd1);
    for (int t = 0; t < 3; t++) cd(1, 1'b1, 1'b0, 2'b01, 2'b00);
    cd(1, 1'b1, 1'b0, 2'b00, 2'b01);
    cd(1, 1'b1, 1'b0, 2'b00, 2'b00);
    cd(1, 1'b1, 1'b0, 2'b10, 2'b00);
    idle_cycles(1, 6);

    // MIN=2, MAX=3, KILL_EARLY=1: early b kills; b at offset 2 matches.
    start_test();
    exp(2, 0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    exp(2, 1, 2'b00, 2'b00, 2'b01, 16'd0, 16'd0, 16'd0, 16'd0);
    exp(2, 2, 2'b00, 2'b01, 2'b00, 16'd0, 16'd0, 16'd1, 16'd0);
    exp(2, 7, 2'b01, 2'b00, 2'b00, 16'd1, 16'd0, 16'd1, 16'd0);
    cd(2, 1'b1, 1'b0, 2'b01, 2'b00);
    cd(2, 1'b1, 1'b0, 2'b00, 2'b01);
    idle_cycles(2, 2);
    cd(2, 1'b1, 1'b0, 2'b01, 2'b00);
    cd(2, 1'b1, 1'b0, 2'b00, 2'b00);
    cd(2, 1'b1, 1'b0, 2'b00, 2'b01);
    idle_cycles(2, 3);

    // MIN=2, MAX=3, KILL_EARLY=0: early b ignored, timeout fail only at offset 3.
    start_test();
    exp(3, 0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    exp(3, 2, 2'b00, 2'b00, 2'b01, 16'd0, 16'd0, 16'd0, 16'd0);
    exp(3, 4, 2'b00, 2'b01, 2'b00, 16'd0, 16'd0, 16'd1, 16'd0);
    cd(3, 1'b1, 1'b0, 2'b01, 2'b00);
    cd(3, 1'b1, 1'b0, 2'b00, 2'b01);
    idle_cycles(3, 5);

    // a and b every cycle 0..9 with MIN=MAX=1: no self-match, nine matches, last attempt times out.
    start_test();
    exp(0, 0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    exp(0, 1, 2'b00, 2'b00, 2'b01, 16'd0, 16'd0, 16'd0, 16'd0);
    for (int t = 2; t <= 10; t++) exp(0, t, 2'b01, 2'b00, 2'b01, 16'(t - 1), 16'd0, 16'd0, 16'd0);
    exp(0, 11, 2'b00, 2'b01, 2'b00, 16'd9, 16'd0, 16'd1, 16'd0);
    for (int t = 0; t < 10; t++) cd(0, 1'b1, 1'b0, 2'b01, 2'b01);
    idle_cycles(0, 3);

    // COUNT_W=2 saturation, clear discarding same-cycle retire, reset mid-attempt without fail.
    start_test();
    exp(4, 0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    for (int t = 2; t <= 6; t++)
      exp(4, t, 2'b01, 2'b00, (t <= 5) ? 2'b01 : 2'b00, (t - 1 > 3) ? 16'd3 : 16'(t - 1), 16'd0, 16'd0, 16'd0);
    exp(4, 8, 2'b00, 2'b00, 2'b01, 16'd3, 16'd0, 16'd0, 16'd0);
    exp(4, 9, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    exp(4, 11, 2'b00, 2'b00, 2'b01, 16'd0, 16'd0, 16'd0, 16'd0);
    exp(4, 12, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    exp(4, 13, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    cd(4, 1'b1, 1'b0, 2'b01, 2'b00);
    for (int t = 1; t <= 4; t++) cd(4, 1'b1, 1'b0, 2'b01, 2'b01);
    cd(4, 1'b1, 1'b0, 2'b00, 2'b01);
    cd(4, 1'b1, 1'b0, 2'b00, 2'b00);
    cd(4, 1'b1, 1'b0, 2'b01, 2'b00);
    cd(4, 1'b1, 1'b1, 2'b11, 2'b01);
    cd(4, 1'b1, 1'b0, 2'b00, 2'b00);
    cd(4, 1'b1, 1'b0, 2'b01, 2'b00);
    idle_all();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_cycles(4, 3);

    // en gating and channel independence on a two-channel monitor.
    start_test();
    exp(0, 0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    exp(0, 3, 2'b00, 2'b00, 2'b01, 16'd0, 16'd0, 16'd0, 16'd0);
    exp(0, 4, 2'b00, 2'b01, 2'b10, 16'd0, 16'd0, 16'd1, 16'd0);
    exp(0, 5, 2'b10, 2'b00, 2'b00, 16'd0, 16'd1, 16'd1, 16'd0);
    exp(0, 6, 2'b00, 2'b00, 2'b00, 16'd0, 16'd1, 16'd1, 16'd0);
    exp(0, 7, 2'b00, 2'b00, 2'b00, 16'd0, 16'd1, 16'd1, 16'd0);
    idle_cycles(0, 2);
    cd(0, 1'b1, 1'b0, 2'b01, 2'b00);
    cd(0, 1'b1, 1'b0, 2'b10, 2'b00);
    cd(0, 1'b0, 1'b0, 2'b01, 2'b10);
    cd(0, 1'b0, 1'b0, 2'b10, 2'b00);
    cd(0, 1'b1, 1'b0, 2'b00, 2'b10);
    idle_cycles(0, 3);

    idle_cycles(0, 2);
    check("sb_drain", 128'(sb_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
